// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an 8-digit 7-segment display.
//
// A shadow frame captures the 56-bit segment bus on load_en. It is copied into
// the active frame only at the end of a digit-7 slot, so a frame never tears.
// Each digit slot lasts CLK_DIV cycles. The first BLANK_CYCLES cycles of a slot
// are dark to suppress ghosting.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   seg[55:0]  : packed frame, seg[7k+6:7k] = digit k, bit0=a .. bit6=g
//   load_en    : capture strobe into the shadow frame
//   brightness : 3-bit dimming level, 7 = full on (only with SEG_DIM_EN)
//   data_out   : segments of the enabled digit (registered)
//   data_pos   : one-hot digit enable, polarity set by POS_ACT_LOW (registered)
//   frame_done : one-cycle pulse after the last cycle of the digit-7 slot
//
// Optional feature macro: SEG_DIM_EN adds the brightness port. In the visible
// window, data_pos is gated by pre[2:0] <= brightness.
module seg_scan_driver #(
  parameter logic [15:0] CLK_DIV      = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd500,
  parameter logic        POS_ACT_LOW  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] seg,
  input  logic        load_en,
`ifdef SEG_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [6:0]  data_out,
  output logic [7:0]  data_pos,
  output logic        frame_done
);

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned FRAME_W    = NUM_DIGITS * SEG_W;
  localparam int unsigned PRE_W      = 16;
  localparam int unsigned IDX_W      = 3;

  localparam logic [NUM_DIGITS-1:0] POS_OFF = POS_ACT_LOW ? 8'hFF : 8'h00;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_W-1:0]    shadow_q, shadow_d;
  logic [FRAME_W-1:0]    active_q, active_d;
  logic                  pend_q, pend_d;
  logic [SEG_W-1:0]      data_out_q, data_out_d;
  logic [NUM_DIGITS-1:0] data_pos_q, data_pos_d;
  logic                  frame_done_q, frame_done_d;

  logic [SEG_W-1:0]      digits [NUM_DIGITS];
  logic                  pre_wrap;
  logic                  frame_end;
  logic                  visible;
  logic                  pos_en;
  logic [NUM_DIGITS-1:0] pos_hot;

  // Split the active frame into per-digit fields for a clean idx-indexed mux.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digits[k] = active_q[SEG_W*k +: SEG_W];
  end

  // Next-state and registered-output logic.
  always_comb begin
    pre_d        = pre_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pend_d       = pend_q;
    data_out_d   = '0;
    data_pos_d   = POS_OFF;
    frame_done_d = 1'b0;

    pre_wrap  = (pre_q == CLK_DIV - 16'd1);
    frame_end = pre_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    if (pre_wrap) begin
      pre_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    // The swap consumes the old shadow. A load on the same edge stays pending
    // for the next frame end.
    if (frame_end && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
    if (load_en) begin
      shadow_d = seg;
      pend_d   = 1'b1;
    end

    visible = (pre_q >= BLANK_CYCLES);
`ifdef SEG_DIM_EN
    pos_en  = visible && (pre_q[2:0] <= brightness);
`else
    pos_en  = visible;
`endif
    pos_hot = NUM_DIGITS'(1) << idx_q;

    if (visible) begin
      data_out_d = digits[idx_q];
    end
    if (pos_en) begin
      data_pos_d = POS_ACT_LOW ? ~pos_hot : pos_hot;
    end
    frame_done_d = frame_end;
  end

  // State and output registers; synchronous reset discards any pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pend_q       <= 1'b0;
      data_out_q   <= '0;
      data_pos_q   <= POS_OFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      data_out_q   <= data_out_d;
      data_pos_q   <= data_pos_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_pos   = data_pos_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with CLK_DIV=4 and BLANK_CYCLES=1.
// Two instances share the inputs: an active-high one and an active-low data_pos one.
// A behavioural model pushes the expected outputs for each cycle into a queue.
// Each scenario task pops those entries and also checks fixed values of its own.
module tb_seg_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;

  typedef struct packed {
    logic [6:0] out;
    logic [7:0] pos;
    logic [7:0] pos_al;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [55:0] seg;
  logic        load_en;
  logic [6:0]  data_out, data_out_al;
  logic [7:0]  data_pos, data_pos_al;
  logic        frame_done, frame_done_al;
`ifdef SEG_DIM_EN
  logic [2:0]  brightness;
`endif

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  // Behavioural model state.
  int          m_pre, m_idx;
  logic [55:0] m_shadow, m_active;
  logic        m_pend;

  seg_scan_driver #(.CLK_DIV(16'd4), .BLANK_CYCLES(16'd1), .POS_ACT_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .seg(seg), .load_en(load_en),
`ifdef SEG_DIM_EN
    .brightness(brightness),
`endif
    .data_out(data_out), .data_pos(data_pos), .frame_done(frame_done)
  );

  seg_scan_driver #(.CLK_DIV(16'd4), .BLANK_CYCLES(16'd1), .POS_ACT_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .seg(seg), .load_en(load_en),
`ifdef SEG_DIM_EN
    .brightness(brightness),
`endif
    .data_out(data_out_al), .data_pos(data_pos_al), .frame_done(frame_done_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, push the model's expectation for it, then advance past the edge.
  task automatic step(input logic r, input logic ld, input logic [55:0] s);
    exp_t e;
    rst = r; load_en = ld; seg = s;
    if (r) begin
      e.out = 7'h00; e.pos = 8'h00; e.pos_al = 8'hFF; e.fd = 1'b0;
      m_pre = 0; m_idx = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
    end else begin
      if (m_pre < BLANK) begin
        e.out = 7'h00; e.pos = 8'h00;
      end else begin
        e.out = m_active[7*m_idx +: 7];
        e.pos = 8'h01 << m_idx;
      end
      e.pos_al = ~e.pos;
      e.fd = (m_idx == 7) && (m_pre == CLK_DIV - 1);
      if (e.fd && m_pend) begin
        m_active = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = s;
        m_pend = 1'b1;
      end
      if (m_pre == CLK_DIV - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_pre = m_pre + 1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [7:0] pos_c;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, {8{7'h7F}});
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL reset_model: out=%h pos=%h fd=%b pos_al=%h exp out=%h pos=%h fd=%b pos_al=%h",
                 data_out, data_pos, frame_done, data_pos_al, e.out, e.pos, e.fd, e.pos_al);
      else n_pass++;
      n_checks++;
      if (data_out !== 7'h00 || data_pos !== 8'h00 || frame_done !== 1'b0 || data_pos_al !== 8'hFF)
        $display("FAIL reset_values: out=%h pos=%h fd=%b pos_al=%h exp 00 00 0 ff",
                 data_out, data_pos, frame_done, data_pos_al);
      else n_pass++;
    end
    for (int k = 0; k < 64; k++) begin
      step(1'b0, 1'b0, 56'h0);
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL scan_model k=%0d: out=%h pos=%h fd=%b pos_al=%h exp out=%h pos=%h fd=%b pos_al=%h",
                 k, data_out, data_pos, frame_done, data_pos_al, e.out, e.pos, e.fd, e.pos_al);
      else n_pass++;
      pos_c = (k % 4 == 0) ? 8'h00 : 8'(1 << ((k / 4) % 8));
      n_checks++;
      if (data_pos !== pos_c || data_out !== 7'h00 || frame_done !== (k % 32 == 31))
        $display("FAIL scan_sequence k=%0d: pos=%h out=%h fd=%b exp pos=%h out=00 fd=%b",
                 k, data_pos, data_out, frame_done, pos_c, (k % 32 == 31));
      else n_pass++;
    end
  endtask

  task automatic test_load_mid_frame();
    exp_t e;
    logic ld, loaded, swapped;
    logic [6:0] want;
    loaded = 1'b0; swapped = 1'b0;
    for (int c = 0; c < 80; c++) begin
      ld = !loaded && m_idx == 3 && m_pre == 2;
      if (ld) loaded = 1'b1;
      step(1'b0, ld, {8{7'h3F}});
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL mid_load_model c=%0d: out=%h pos=%h fd=%b pos_al=%h exp out=%h pos=%h fd=%b pos_al=%h",
                 c, data_out, data_pos, frame_done, data_pos_al, e.out, e.pos, e.fd, e.pos_al);
      else n_pass++;
      if (e.pos != 8'h00) begin
        want = swapped ? 7'h3F : 7'h00;
        n_checks++;
        if (data_out !== want)
          $display("FAIL mid_load_frame c=%0d: out=%h exp %h", c, data_out, want);
        else n_pass++;
      end
      if (e.fd) swapped = 1'b1;
    end
    n_checks++;
    if (!(loaded && swapped)) $display("FAIL mid_load_reached: loaded=%b swapped=%b exp 1 1", loaded, swapped);
    else n_pass++;
  endtask

  task automatic test_double_load();
    exp_t e;
    logic ld;
    logic swapped;
    logic [55:0] s;
    swapped = 1'b0;
    for (int c = 0; c < 64; c++) begin
      ld = 1'b0; s = 56'h0;
      if (m_idx == 5 && m_pre == 1 && !swapped) begin ld = 1'b1; s = {49'h0, 7'h06}; end
      if (m_idx == 6 && m_pre == 1 && !swapped) begin ld = 1'b1; s = {49'h0, 7'h5B}; end
      step(1'b0, ld, s);
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL double_load_model c=%0d: out=%h pos=%h fd=%b exp out=%h pos=%h fd=%b",
                 c, data_out, data_pos, frame_done, e.out, e.pos, e.fd);
      else n_pass++;
      if (e.pos == 8'h01) begin
        n_checks++;
        if (data_out !== 7'h5B)
          $display("FAIL double_load_digit0 c=%0d: out=%h exp 5b", c, data_out);
        else n_pass++;
      end else if (e.pos != 8'h00 && swapped) begin
        n_checks++;
        if (data_out !== 7'h00)
          $display("FAIL double_load_other c=%0d: out=%h exp 00", c, data_out);
        else n_pass++;
      end
      if (e.fd) swapped = 1'b1;
    end
  endtask

  task automatic test_swap_edge();
    exp_t e;
    logic ld;
    logic [55:0] s;
    int nf;
    logic [6:0] want;
    nf = 0;
    for (int c = 0; c < 96; c++) begin
      ld = 1'b0; s = 56'h0;
      if (nf == 0 && m_idx == 5 && m_pre == 1) begin ld = 1'b1; s = {49'h0, 7'h77}; end
      if (nf == 0 && m_idx == 7 && m_pre == 3) begin ld = 1'b1; s = {49'h0, 7'h66}; end
      step(1'b0, ld, s);
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL swap_edge_model c=%0d: out=%h pos=%h fd=%b exp out=%h pos=%h fd=%b",
                 c, data_out, data_pos, frame_done, e.out, e.pos, e.fd);
      else n_pass++;
      if (e.pos == 8'h01) begin
        want = (nf == 1) ? 7'h77 : 7'h66;
        n_checks++;
        if (data_out !== want)
          $display("FAIL swap_edge_digit0 frame=%0d: out=%h exp %h", nf, data_out, want);
        else n_pass++;
      end
      if (e.fd) nf++;
    end
    n_checks++;
    if (nf != 3) $display("FAIL swap_edge_frames: frames=%0d exp 3", nf);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic ld, r, loaded, rdone;
    logic [7:0] pos_c;
    int k;
    loaded = 1'b0; rdone = 1'b0; k = -1;
    for (int c = 0; c < 60; c++) begin
      ld = !loaded && m_idx == 5 && m_pre == 1;
      r  = loaded && !rdone && m_idx == 5 && m_pre == 3;
      if (ld) loaded = 1'b1;
      step(r, ld, {8{7'h7F}});
      e = exp_q.pop_front();
      n_checks++;
      if (data_out !== e.out || data_pos !== e.pos || frame_done !== e.fd ||
          data_pos_al !== e.pos_al || data_out_al !== e.out)
        $display("FAIL reset_mid_model c=%0d: out=%h pos=%h fd=%b exp out=%h pos=%h fd=%b",
                 c, data_out, data_pos, frame_done, e.out, e.pos, e.fd);
      else n_pass++;
      if (r) begin
        rdone = 1'b1;
        k = 0;
      end else if (k >= 0) begin
        pos_c = (k % 4 == 0) ? 8'h00 : 8'(1 << ((k / 4) % 8));
        n_checks++;
        if (data_out !== 7'h00 || data_pos !== pos_c || frame_done !== (k % 32 == 31))
          $display("FAIL reset_mid_restart k=%0d: out=%h pos=%h fd=%b exp out=00 pos=%h fd=%b",
                   k, data_out, data_pos, frame_done, pos_c, (k % 32 == 31));
        else n_pass++;
        k++;
      end
    end
    n_checks++;
    if (!rdone) $display("FAIL reset_mid_reached: reset not applied, exp 1");
    else n_pass++;
  endtask

  task automatic test_active_low();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b0, 56'h0);
      e = exp_q.pop_front();
      n_checks++;
      if (data_pos_al !== e.pos_al || data_pos !== e.pos || frame_done_al !== e.fd)
        $display("FAIL active_low_model c=%0d: pos_al=%h pos=%h exp pos_al=%h pos=%h",
                 c, data_pos_al, data_pos, e.pos_al, e.pos);
      else n_pass++;
      if (e.pos == 8'h00) begin
        n_checks++;
        if (data_pos_al !== 8'hFF) $display("FAIL active_low_blank c=%0d: pos_al=%h exp ff", c, data_pos_al);
        else n_pass++;
      end else if (e.pos == 8'h04) begin
        n_checks++;
        if (data_pos_al !== 8'hFB) $display("FAIL active_low_digit2 c=%0d: pos_al=%h exp fb", c, data_pos_al);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    load_en  = 1'b0;
    seg      = '0;
`ifdef SEG_DIM_EN
    brightness = 3'd7;
`endif
    m_pre = 0; m_idx = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
    #1;
    test_reset();
    test_load_mid_frame();
    test_double_load();
    test_swap_edge();
    test_reset_mid();
    test_active_low();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
